// File: rtl/bp_1bit_predictor_if.sv
// ---------------------------------------------------------------------------
// bp_1bit_predictor_if
// Bundles the fetch-side lookup handshake, the prediction result, the
// resolve/flush inputs from the back end and the status outputs of the
// 1-bit branch predictor.
//
// Signals:
//   LOOKUP_VALID  fetch presents a branch PC this cycle
//   LOOKUP_READY  predictor can accept a lookup (tracking FIFO not full)
//   LOOKUP_PC     branch PC of the lookup
//   PREDICT_VALID registered: prediction for the last accepted lookup
//   PREDICT_TAKEN registered predicted direction
//   RESOLVE_VALID oldest in-flight branch resolved this cycle
//   RESOLVE_TAKEN actual direction of that branch
//   FLUSH         discard all in-flight predictions
//   MISS          registered one-cycle misprediction pulse
//   RESOLVE_ERR   sticky: a resolve arrived with nothing in flight
//
// Modports:
//   master - the pipeline side (drives lookups, resolves, flush)
//   slave  - the predictor
// ---------------------------------------------------------------------------
interface bp_1bit_predictor_if #(
    parameter int PC_WIDTH = 32
);
    logic                LOOKUP_VALID;
    logic                LOOKUP_READY;
    logic [PC_WIDTH-1:0] LOOKUP_PC;
    logic                PREDICT_VALID;
    logic                PREDICT_TAKEN;
    logic                RESOLVE_VALID;
    logic                RESOLVE_TAKEN;
    logic                FLUSH;
    logic                MISS;
    logic                RESOLVE_ERR;

    modport master (
        output LOOKUP_VALID,
        output LOOKUP_PC,
        output RESOLVE_VALID,
        output RESOLVE_TAKEN,
        output FLUSH,
        input  LOOKUP_READY,
        input  PREDICT_VALID,
        input  PREDICT_TAKEN,
        input  MISS,
        input  RESOLVE_ERR
    );

    modport slave (
        input  LOOKUP_VALID,
        input  LOOKUP_PC,
        input  RESOLVE_VALID,
        input  RESOLVE_TAKEN,
        input  FLUSH,
        output LOOKUP_READY,
        output PREDICT_VALID,
        output PREDICT_TAKEN,
        output MISS,
        output RESOLVE_ERR
    );
endinterface

// File: rtl/bp_1bit_predictor.sv
// ---------------------------------------------------------------------------
// bp_1bit_predictor
// 1-bit branch predictor. Each lookup reads a per-index taken/not-taken bit,
// returns it one cycle later and records {index, prediction} in an in-order
// tracking FIFO. Each resolve pops the oldest record, writes the actual
// direction back into the table and pulses MISS when the prediction was
// wrong. MISS feeds the MISS input of the miss counter.
//
// Ports:
//   CLOCK  in   sole clock, rising edge
//   INIT   in   synchronous active-high reset (clears table, FIFO, outputs)
//   bus    slave modport of bp_1bit_predictor_if (lookup / predict /
//          resolve / flush / MISS / RESOLVE_ERR)
//
// Parameters:
//   INDEX_BITS  table index width, 2**INDEX_BITS one-bit entries
//   PC_WIDTH    PC width; index = PC[INDEX_BITS+1:2]
//   DEPTH_LOG2  log2 of the tracking FIFO depth
//
// Configuration macro:
//   BP_BYPASS_EN  when defined, a lookup to the index being trained in the
//                 same cycle predicts the new (resolved) value; when
//                 undefined the lookup sees the pre-update table value.
// ---------------------------------------------------------------------------
module bp_1bit_predictor #(
    parameter int INDEX_BITS = 6,
    parameter int PC_WIDTH   = 32,
    parameter int DEPTH_LOG2 = 2
) (
    input logic                CLOCK,
    input logic                INIT,
    bp_1bit_predictor_if.slave bus
);

    localparam int ENTRIES = 1 << INDEX_BITS;
    localparam int DEPTH   = 1 << DEPTH_LOG2;

    localparam logic [DEPTH_LOG2:0]   FULL_COUNT = (DEPTH_LOG2 + 1)'(DEPTH);
    localparam logic [DEPTH_LOG2:0]   CNT_ONE    = (DEPTH_LOG2 + 1)'(1);
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE    = DEPTH_LOG2'(1);

    typedef logic [INDEX_BITS-1:0] idx_t;

    typedef struct packed {
        idx_t idx;
        logic pred;
    } entry_t;

    logic [ENTRIES-1:0]    table_q, table_d;
    entry_t                fifo_q [DEPTH];
    entry_t                fifo_d [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
    logic [DEPTH_LOG2:0]   count_q, count_d;
    logic                  predict_valid_q, predict_valid_d;
    logic                  predict_taken_q, predict_taken_d;
    logic                  miss_q, miss_d;
    logic                  resolve_err_q, resolve_err_d;

    idx_t   lookup_idx;
    entry_t head;
    logic   fifo_empty;
    logic   ready;
    logic   accept;
    logic   push;
    logic   pop;
    logic   lookup_bit;
    logic   unused_pc_bits;

    assign lookup_idx     = bus.LOOKUP_PC[INDEX_BITS+1:2];
    assign unused_pc_bits = ^{bus.LOOKUP_PC[PC_WIDTH-1:INDEX_BITS+2],
                              bus.LOOKUP_PC[1:0]};

    assign head       = fifo_q[rd_ptr_q];
    assign fifo_empty = (count_q == '0);

    // Readiness depends on occupancy only, so a pop in the same cycle never
    // frees a slot for a push while the FIFO is full.
    assign ready  = (count_q != FULL_COUNT);
    assign accept = bus.LOOKUP_VALID & ready;

    // A flush discards the same-cycle lookup; a same-cycle resolve is still
    // serviced because it is ordered before the flush.
    assign push = accept & ~bus.FLUSH;
    assign pop  = bus.RESOLVE_VALID & ~fifo_empty;

    // Direction returned for this cycle's lookup. With forwarding enabled a
    // lookup colliding with the entry being trained sees the trained value.
    always_comb begin
        lookup_bit = table_q[lookup_idx];
`ifdef BP_BYPASS_EN
        if (pop && (head.idx == lookup_idx)) begin
            lookup_bit = bus.RESOLVE_TAKEN;
        end
`endif
    end

    // Next-state computation for the table, FIFO bookkeeping and the
    // registered outputs.
    always_comb begin
        table_d         = table_q;
        fifo_d          = fifo_q;
        wr_ptr_d        = wr_ptr_q;
        rd_ptr_d        = rd_ptr_q;
        count_d         = count_q;
        predict_valid_d = 1'b0;
        predict_taken_d = predict_taken_q;
        miss_d          = 1'b0;
        resolve_err_d   = resolve_err_q;

        if (pop) begin
            table_d[head.idx] = bus.RESOLVE_TAKEN;
            rd_ptr_d          = rd_ptr_q + PTR_ONE;
            miss_d            = (head.pred != bus.RESOLVE_TAKEN);
        end

        // A resolve with nothing in flight is dropped but remembered.
        if (bus.RESOLVE_VALID && fifo_empty) begin
            resolve_err_d = 1'b1;
        end

        if (push) begin
            fifo_d[wr_ptr_q] = '{idx: lookup_idx, pred: lookup_bit};
            wr_ptr_d         = wr_ptr_q + PTR_ONE;
            predict_valid_d  = 1'b1;
            predict_taken_d  = lookup_bit;
        end

        case ({push, pop})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase

        if (bus.FLUSH) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end
    end

    // State and output registers; INIT wins over every other input.
    always_ff @(posedge CLOCK) begin
        if (INIT) begin
            table_q         <= '0;
            wr_ptr_q        <= '0;
            rd_ptr_q        <= '0;
            count_q         <= '0;
            predict_valid_q <= 1'b0;
            predict_taken_q <= 1'b0;
            miss_q          <= 1'b0;
            resolve_err_q   <= 1'b0;
        end else begin
            table_q         <= table_d;
            wr_ptr_q        <= wr_ptr_d;
            rd_ptr_q        <= rd_ptr_d;
            count_q         <= count_d;
            predict_valid_q <= predict_valid_d;
            predict_taken_q <= predict_taken_d;
            miss_q          <= miss_d;
            resolve_err_q   <= resolve_err_d;
        end
    end

    // FIFO payload storage needs no reset: occupancy is governed solely by
    // the pointers and count, so stale entries are never observed.
    always_ff @(posedge CLOCK) begin
        fifo_q <= fifo_d;
    end

    assign bus.LOOKUP_READY  = ready;
    assign bus.PREDICT_VALID = predict_valid_q;
    assign bus.PREDICT_TAKEN = predict_taken_q;
    assign bus.MISS          = miss_q;
    assign bus.RESOLVE_ERR   = resolve_err_q;

endmodule

// File: tb/tb_bp_1bit_predictor.sv
// ---------------------------------------------------------------------------
// tb_bp_1bit_predictor
// Self-checking bench for bp_1bit_predictor: reset checks, a table of
// directed vectors with hand-computed expectations, a push/pop wrap
// sequence and a randomized phase, all compared against a queue-based
// reference model of the predictor.
// ---------------------------------------------------------------------------
module tb_bp_1bit_predictor;

    localparam int INDEX_BITS = 6;
    localparam int PC_WIDTH   = 32;
    localparam int DEPTH_LOG2 = 2;
    localparam int DEPTH      = 1 << DEPTH_LOG2;
    localparam int ENTRIES    = 1 << INDEX_BITS;

`ifdef BP_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    logic clk  = 1'b0;
    logic init = 1'b0;

    always #5 clk = ~clk;

    bp_1bit_predictor_if #(.PC_WIDTH(PC_WIDTH)) bus ();

    bp_1bit_predictor #(
        .INDEX_BITS(INDEX_BITS),
        .PC_WIDTH  (PC_WIDTH),
        .DEPTH_LOG2(DEPTH_LOG2)
    ) dut (
        .CLOCK(clk),
        .INIT (init),
        .bus  (bus)
    );

    // Reference model: table as a plain bit array, in-flight branches as a
    // queue of {index, predicted direction}.
    typedef struct {
        int idx;
        bit pred;
    } flight_t;

    flight_t m_q[$];
    bit      m_table [ENTRIES];
    bit      m_pv, m_pt, m_miss, m_err;

    int total = 0;
    int bad   = 0;

    typedef struct {
        bit          i_init;
        bit          i_lv;
        logic [31:0] i_pc;
        bit          i_rv;
        bit          i_rt;
        bit          i_fl;
        bit          e_rdy;
        bit          e_pv;
        bit          e_pt;
        bit          e_miss;
        bit          e_err;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(bit i_init, bit i_lv, logic [31:0] i_pc, bit i_rv,
                                bit i_rt, bit i_fl, bit e_rdy, bit e_pv, bit e_pt,
                                bit e_miss, bit e_err);
        vec_t v;
        v.i_init = i_init; v.i_lv = i_lv; v.i_pc = i_pc; v.i_rv = i_rv;
        v.i_rt = i_rt; v.i_fl = i_fl; v.e_rdy = e_rdy; v.e_pv = e_pv;
        v.e_pt = e_pt; v.e_miss = e_miss; v.e_err = e_err;
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic act, input bit exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %b, wanted %b (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive(input bit i_init, input bit lv, input logic [31:0] pc,
                         input bit rv, input bit rt, input bit fl);
        init              = i_init;
        bus.LOOKUP_VALID  = lv;
        bus.LOOKUP_PC     = pc;
        bus.RESOLVE_VALID = rv;
        bus.RESOLVE_TAKEN = rt;
        bus.FLUSH         = fl;
    endtask

    // Advance the model by one clock using the inputs currently driven.
    task automatic model_step();
        bit      rdy, accept, pop_ok, v;
        int      lidx;
        flight_t hd;
        flight_t nf;
        if (init) begin
            foreach (m_table[k]) m_table[k] = 1'b0;
            m_q.delete();
            m_pv = 0; m_pt = 0; m_miss = 0; m_err = 0;
            return;
        end
        rdy    = (m_q.size() != DEPTH);
        accept = bus.LOOKUP_VALID && rdy;
        pop_ok = bus.RESOLVE_VALID && (m_q.size() > 0);
        lidx   = int'(bus.LOOKUP_PC[INDEX_BITS+1:2]);
        v      = m_table[lidx];
        m_miss = 1'b0;
        if (pop_ok) begin
            hd = m_q.pop_front();
            if (BYPASS && hd.idx == lidx) v = bus.RESOLVE_TAKEN;
            m_miss = (hd.pred != bus.RESOLVE_TAKEN);
            m_table[hd.idx] = bus.RESOLVE_TAKEN;
        end else if (bus.RESOLVE_VALID) begin
            m_err = 1'b1;
        end
        if (bus.FLUSH) begin
            m_q.delete();
            m_pv = 1'b0;
        end else begin
            m_pv = accept;
            if (accept) begin
                m_pt    = v;
                nf.idx  = lidx;
                nf.pred = v;
                m_q.push_back(nf);
            end
        end
    endtask

    // One clock of stimulus: check readiness before the edge, advance the
    // model, then compare the registered outputs just after the edge.
    task automatic applyStimulus(input bit chk_ready);
        if (chk_ready) checkOutput("ready_model", bus.LOOKUP_READY, m_q.size() != DEPTH);
        model_step();
        @(posedge clk);
        #1;
        checkOutput("pv_model",   bus.PREDICT_VALID, m_pv);
        checkOutput("pt_model",   bus.PREDICT_TAKEN, m_pt);
        checkOutput("miss_model", bus.MISS,          m_miss);
        checkOutput("err_model",  bus.RESOLVE_ERR,   m_err);
    endtask

    initial begin
        drive(1, 0, 32'h0, 0, 0, 0);
        @(posedge clk);
        #1;
        applyStimulus(0);
        checkOutput("reset_ready", bus.LOOKUP_READY, 1'b1);

        // Directed vectors: {init, lv, pc, rv, rt, flush, rdy, pv, pt, miss, err}
        vecs.push_back(mk(0, 1, 32'h40, 0, 0, 0, 1, 1, 0, 0, 0)); // lookup idx16
        vecs.push_back(mk(0, 0, 32'h00, 1, 1, 0, 1, 0, 0, 1, 0)); // mispredict
        vecs.push_back(mk(0, 0, 32'h00, 0, 0, 0, 1, 0, 0, 0, 0)); // MISS drops
        vecs.push_back(mk(0, 1, 32'h40, 0, 0, 0, 1, 1, 1, 0, 0)); // trained
        vecs.push_back(mk(0, 0, 32'h00, 1, 1, 0, 1, 0, 1, 0, 0)); // correct
        vecs.push_back(mk(0, 1, 32'h00, 0, 0, 0, 1, 1, 0, 0, 0)); // fill 1
        vecs.push_back(mk(0, 1, 32'h04, 0, 0, 0, 1, 1, 0, 0, 0)); // fill 2
        vecs.push_back(mk(0, 1, 32'h08, 0, 0, 0, 1, 1, 0, 0, 0)); // fill 3
        vecs.push_back(mk(0, 1, 32'h0C, 0, 0, 0, 1, 1, 0, 0, 0)); // fill 4
        vecs.push_back(mk(0, 1, 32'h40, 0, 0, 0, 0, 0, 0, 0, 0)); // 5th refused
        vecs.push_back(mk(0, 0, 32'h00, 1, 0, 0, 0, 0, 0, 0, 0)); // pop when full
        vecs.push_back(mk(0, 0, 32'h00, 0, 0, 0, 1, 0, 0, 0, 0)); // ready again
        vecs.push_back(mk(0, 1, 32'h40, 1, 1, 1, 1, 0, 0, 1, 0)); // flush+resolve
        vecs.push_back(mk(0, 0, 32'h00, 1, 1, 0, 1, 0, 0, 0, 1)); // empty resolve
        vecs.push_back(mk(0, 0, 32'h00, 0, 0, 0, 1, 0, 0, 0, 1)); // err sticky
        vecs.push_back(mk(1, 0, 32'h00, 0, 0, 0, 1, 0, 0, 0, 0)); // init clears
        vecs.push_back(mk(0, 1, 32'h80, 0, 0, 0, 1, 1, 0, 0, 0)); // lookup idx32
        vecs.push_back(mk(0, 1, 32'h80, 1, 1, 0, 1, 1, BYPASS, 1, 0)); // collide
        vecs.push_back(mk(0, 1, 32'h80, 0, 0, 0, 1, 1, 1, 0, 0)); // trained
        vecs.push_back(mk(1, 1, 32'h80, 1, 1, 1, 1, 0, 0, 0, 0)); // init mid-stream

        foreach (vecs[n]) begin
            drive(vecs[n].i_init, vecs[n].i_lv, vecs[n].i_pc,
                  vecs[n].i_rv, vecs[n].i_rt, vecs[n].i_fl);
            checkOutput($sformatf("vec%0d_ready", n), bus.LOOKUP_READY, vecs[n].e_rdy);
            applyStimulus(1);
            checkOutput($sformatf("vec%0d_pv", n),   bus.PREDICT_VALID, vecs[n].e_pv);
            checkOutput($sformatf("vec%0d_pt", n),   bus.PREDICT_TAKEN, vecs[n].e_pt);
            checkOutput($sformatf("vec%0d_miss", n), bus.MISS,          vecs[n].e_miss);
            checkOutput($sformatf("vec%0d_err", n),  bus.RESOLVE_ERR,   vecs[n].e_err);
        end

        // Pointer wrap: keep one branch in flight and push/pop together.
        drive(0, 1, 32'h40, 0, 0, 0);
        applyStimulus(1);
        for (int i = 0; i < 12; i++) begin
            drive(0, 1, 32'(i * 4), 1, i[0], 0);
            applyStimulus(1);
        end
        drive(0, 0, 32'h0, 0, 0, 0);
        applyStimulus(1);

        // Randomized traffic with frequent index collisions.
        for (int i = 0; i < 2000; i++) begin
            logic [31:0] pc;
            pc      = $urandom;
            pc[7:2] = 6'($urandom_range(0, 7));
            drive($urandom_range(0, 99) == 0,
                  $urandom_range(0, 99) < 60,
                  pc,
                  $urandom_range(0, 99) < 40,
                  $urandom_range(0, 1) == 1,
                  $urandom_range(0, 99) < 3);
            applyStimulus(1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
